// File: rtl/booth_xor_pipe_if.sv
// Handshake bundle for booth_xor_pipe: operand/mode input side, result output
// side and the completed-transfer counter. The stage itself uses the slave view.
interface booth_xor_pipe_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;
  logic             out_neg_carry;
  logic             out_parity;
  logic [CNT_W-1:0] xfer_count;

  modport slave (
    input  in_valid, in_a, in_b, in_mode, out_ready,
    output in_ready, out_valid, out_y, out_neg_carry, out_parity, xfer_count
  );

  modport master (
    output in_valid, in_a, in_b, in_mode, out_ready,
    input  in_ready, out_valid, out_y, out_neg_carry, out_parity, xfer_count
  );
endinterface

// File: rtl/booth_xor_pipe.sv
// Registered bitwise-logic stage for the Booth multiplier datapath.
// Each accepted operand pair is reduced to (result, negate carry, parity) at the
// input and parked in a 2-entry FIFO so the stage keeps one result per cycle
// even when the partial-product accumulator stalls for a cycle.
module booth_xor_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  booth_xor_pipe_if.slave bus
);

  localparam logic [1:0] MODE_XOR  = 2'b00;
  localparam logic [1:0] MODE_XNOR = 2'b01;
  localparam logic [1:0] MODE_PASS = 2'b10;
  localparam logic [1:0] MODE_NEG  = 2'b11;

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic             neg_carry;
    logic             parity;
  } entry_t;

  // Lane operation; NEG produces the one's complement and flags the +1 that the
  // downstream adder folds in through its carry input to finish two's negation.
  function automatic entry_t compute_entry(input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b,
                                           input logic [1:0]       mode);
    entry_t e;
    e.y         = '0;
    e.neg_carry = 1'b0;
    case (mode)
      MODE_XOR:  e.y = a ^ b;
      MODE_XNOR: e.y = ~(a ^ b);
      MODE_PASS: e.y = a;
      MODE_NEG: begin
        e.y         = ~a;
        e.neg_carry = 1'b1;
      end
      default:   e.y = '0;
    endcase
    e.parity = ^e.y;
    return e;
  endfunction

  // Stage p0: combinational result for the operands currently presented
  entry_t entry_p0;

  // Stage p1: buffered results plus FIFO control
  entry_t           mem_p1 [2];
  logic             wr_ptr_p1;
  logic             rd_ptr_p1;
  logic [1:0]       occ_p1;
  logic [CNT_W-1:0] xfer_cnt_p1;

  logic   ready_p0;
  logic   vld_p1;
  logic   push;
  logic   pop;
  entry_t head_p1;

  // in_ready looks only at registered occupancy (and reset), never at out_ready,
  // so no combinational path runs from the consumer back to the producer.
  assign ready_p0 = (occ_p1 != 2'd2) & rst_n;
  assign vld_p1   = (occ_p1 != 2'd0);
  assign push     = bus.in_valid & ready_p0;
  assign pop      = vld_p1 & bus.out_ready;
  assign head_p1  = mem_p1[rd_ptr_p1];

  // Compute result, carry and parity for the incoming operands
  always_comb begin
    entry_p0 = compute_entry(bus.in_a, bus.in_b, bus.in_mode);
  end

  // ---- p0 -> p1 boundary ----

  // Data storage: written only on push; stale contents are masked by occupancy
  always_ff @(posedge clk) begin
    if (push) begin
      mem_p1[wr_ptr_p1] <= entry_p0;
    end
  end

  // FIFO pointers, occupancy and transfer counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_p1   <= 1'b0;
      rd_ptr_p1   <= 1'b0;
      occ_p1      <= 2'd0;
      xfer_cnt_p1 <= '0;
    end else begin
      if (push) begin
        wr_ptr_p1 <= ~wr_ptr_p1;
      end
      if (pop) begin
        rd_ptr_p1   <= ~rd_ptr_p1;
        xfer_cnt_p1 <= xfer_cnt_p1 + 1'b1;
      end
      case ({push, pop})
        2'b10:   occ_p1 <= occ_p1 + 2'd1;
        2'b01:   occ_p1 <= occ_p1 - 2'd1;
        default: occ_p1 <= occ_p1;
      endcase
    end
  end

  // Output fields are zero whenever no result is held
  always_comb begin
    bus.in_ready      = ready_p0;
    bus.out_valid     = vld_p1;
    bus.out_y         = vld_p1 ? head_p1.y : '0;
    bus.out_neg_carry = vld_p1 & head_p1.neg_carry;
    bus.out_parity    = vld_p1 & head_p1.parity;
    bus.xfer_count    = xfer_cnt_p1;
  end

endmodule

// File: tb/tb_booth_xor_pipe.sv
// Directed bench for booth_xor_pipe: an 8-lane instance with a 16-bit counter
// and a 16-lane instance with a 4-bit counter share clock and reset.
module tb_booth_xor_pipe;

  logic clk;
  logic rst_n;

  int n_checks;
  int n_errors;

  booth_xor_pipe_if #(.WIDTH(8),  .CNT_W(16)) if8  ();
  booth_xor_pipe_if #(.WIDTH(16), .CNT_W(4))  if16 ();

  booth_xor_pipe #(.WIDTH(8), .CNT_W(16)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if8)
  );

  booth_xor_pipe #(.WIDTH(16), .CNT_W(4)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive8(input logic v, input logic [7:0] a, input logic [7:0] b,
                        input logic [1:0] m);
    if8.in_valid = v;
    if8.in_a     = a;
    if8.in_b     = b;
    if8.in_mode  = m;
  endtask

  function automatic logic [7:0] model_y(input logic [7:0] a, input logic [7:0] b,
                                         input logic [1:0] m);
    case (m)
      2'b00:   return a ^ b;
      2'b01:   return ~(a ^ b);
      2'b10:   return a;
      default: return ~a;
    endcase
  endfunction

  logic [7:0] s_a [100];
  logic [7:0] s_b [100];
  logic [1:0] s_m [100];

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    drive8(1'b1, 8'hFF, 8'h00, 2'b00);
    if8.out_ready   = 1'b0;
    if16.in_valid   = 1'b0;
    if16.in_a       = '0;
    if16.in_b       = '0;
    if16.in_mode    = 2'b00;
    if16.out_ready  = 1'b0;

    // Reset held for three edges with in_valid asserted
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_in_ready", 32'(if8.in_ready), 32'd0);
      check("rst_out_valid", 32'(if8.out_valid), 32'd0);
      check("rst_out_y", 32'(if8.out_y), 32'd0);
      check("rst_xfer", 32'(if8.xfer_count), 32'd0);
    end
    drive8(1'b0, 8'h00, 8'h00, 2'b00);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(if8.in_ready), 32'd1);
    check("post_rst_out_valid", 32'(if8.out_valid), 32'd0);

    // Mode vectors, each visible one cycle after acceptance
    if8.out_ready = 1'b1;
    drive8(1'b1, 8'hA5, 8'h3C, 2'b00);
    tick();
    drive8(1'b0, 8'h00, 8'h00, 2'b00);
    check("xor_valid", 32'(if8.out_valid), 32'd1);
    check("xor_y", 32'(if8.out_y), 32'h99);
    check("xor_par", 32'(if8.out_parity), 32'd0);
    check("xor_carry", 32'(if8.out_neg_carry), 32'd0);
    tick();
    check("xor_drain", 32'(if8.out_valid), 32'd0);
    check("xor_idle_y", 32'(if8.out_y), 32'd0);

    drive8(1'b1, 8'hA5, 8'h3C, 2'b01);
    tick();
    drive8(1'b0, 8'h00, 8'h00, 2'b00);
    check("xnor_y", 32'(if8.out_y), 32'h66);
    check("xnor_carry", 32'(if8.out_neg_carry), 32'd0);
    tick();

    drive8(1'b1, 8'hA5, 8'h3C, 2'b10);
    tick();
    drive8(1'b0, 8'h00, 8'h00, 2'b00);
    check("pass_y", 32'(if8.out_y), 32'hA5);
    tick();

    drive8(1'b1, 8'h05, 8'h3C, 2'b11);
    tick();
    drive8(1'b0, 8'h00, 8'h00, 2'b00);
    check("neg_valid", 32'(if8.out_valid), 32'd1);
    check("neg_y", 32'(if8.out_y), 32'hFA);
    check("neg_carry", 32'(if8.out_neg_carry), 32'd1);
    check("neg_par", 32'(if8.out_parity), 32'd0);
    tick();
    check("neg_carry_idle", 32'(if8.out_neg_carry), 32'd0);
    check("modes_xfer", 32'(if8.xfer_count), 32'd4);

    // Back-pressure: two accepted, third held until space opens
    if8.out_ready = 1'b0;
    drive8(1'b1, 8'h01, 8'h00, 2'b00);
    tick();
    check("bp_ready1", 32'(if8.in_ready), 32'd1);
    check("bp_par1", 32'(if8.out_parity), 32'd1);
    drive8(1'b1, 8'h02, 8'h00, 2'b00);
    tick();
    check("bp_ready2", 32'(if8.in_ready), 32'd0);
    drive8(1'b1, 8'h03, 8'h00, 2'b00);
    tick();
    check("bp_hold_ready", 32'(if8.in_ready), 32'd0);
    check("bp_hold_y", 32'(if8.out_y), 32'h01);
    check("bp_hold_xfer", 32'(if8.xfer_count), 32'd4);
    if8.out_ready = 1'b1;
    tick();
    check("bp_pop1_ready", 32'(if8.in_ready), 32'd1);
    check("bp_y2", 32'(if8.out_y), 32'h02);
    tick();
    drive8(1'b0, 8'h00, 8'h00, 2'b00);
    check("bp_y3", 32'(if8.out_y), 32'h03);
    check("bp_par3", 32'(if8.out_parity), 32'd0);
    tick();
    check("bp_empty", 32'(if8.out_valid), 32'd0);
    check("bp_xfer", 32'(if8.xfer_count), 32'd7);

    // Streaming: 100 back-to-back inputs with the consumer always ready
    for (int i = 0; i < 100; i++) begin
      s_a[i] = 8'($urandom);
      s_b[i] = 8'($urandom);
      s_m[i] = 2'($urandom_range(0, 3));
    end
    for (int i = 0; i < 100; i++) begin
      drive8(1'b1, s_a[i], s_b[i], s_m[i]);
      check("st_ready", 32'(if8.in_ready), 32'd1);
      tick();
      check("st_valid", 32'(if8.out_valid), 32'd1);
      check("st_y", 32'(if8.out_y), 32'(model_y(s_a[i], s_b[i], s_m[i])));
      check("st_carry", 32'(if8.out_neg_carry), 32'(s_m[i] == 2'b11));
    end
    drive8(1'b0, 8'h00, 8'h00, 2'b00);
    tick();
    check("st_drain", 32'(if8.out_valid), 32'd0);
    check("st_xfer", 32'(if8.xfer_count), 32'd107);

    // Reset with two entries buffered
    if8.out_ready = 1'b0;
    drive8(1'b1, 8'hAA, 8'h00, 2'b10);
    tick();
    drive8(1'b1, 8'h55, 8'h00, 2'b10);
    tick();
    drive8(1'b0, 8'h00, 8'h00, 2'b00);
    check("mr_full", 32'(if8.in_ready), 32'd0);
    rst_n = 1'b0;
    tick();
    check("mr_valid", 32'(if8.out_valid), 32'd0);
    check("mr_xfer", 32'(if8.xfer_count), 32'd0);
    check("mr_ready_low", 32'(if8.in_ready), 32'd0);
    rst_n = 1'b1;
    if8.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mr_no_old", 32'(if8.out_valid), 32'd0);
    end
    drive8(1'b1, 8'h3C, 8'h00, 2'b10);
    tick();
    drive8(1'b0, 8'h00, 8'h00, 2'b00);
    check("mr_new_y", 32'(if8.out_y), 32'h3C);
    tick();
    check("mr_new_xfer", 32'(if8.xfer_count), 32'd1);

    // Wide instance: NEG of 1 and counter wrap at 16
    if16.out_ready = 1'b1;
    if16.in_valid  = 1'b1;
    if16.in_a      = 16'h0001;
    if16.in_b      = 16'h1234;
    if16.in_mode   = 2'b11;
    tick();
    if16.in_valid  = 1'b0;
    check("w_neg_y", 32'(if16.out_y), 32'hFFFE);
    check("w_neg_carry", 32'(if16.out_neg_carry), 32'd1);
    check("w_neg_par", 32'(if16.out_parity), 32'd1);
    tick();
    check("w_xfer1", 32'(if16.xfer_count), 32'd1);
    if16.in_mode = 2'b00;
    for (int i = 0; i < 16; i++) begin
      if16.in_valid = 1'b1;
      if16.in_a     = 16'(i);
      if16.in_b     = 16'hFF00;
      tick();
      check("w_st_y", 32'(if16.out_y), 32'(16'(i) ^ 16'hFF00));
      if (i == 14) begin
        check("w_xfer15", 32'(if16.xfer_count), 32'd15);
      end
    end
    if16.in_valid = 1'b0;
    tick();
    check("w_xfer_wrap", 32'(if16.xfer_count), 32'd1);
    check("w_drain", 32'(if16.out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
